// File: rtl/paddle_motion.sv
// ---------------------------------------------------------------------------
// paddle_motion
//
// Brick-breaker paddle controller. A divided motion tick moves the paddle
// left or right with speed ramping while a key is held, handles a timed
// wide-paddle power-up (re-centred on widen/narrow), honours a freeze input,
// and draws the paddle into the VGA colour stream.
//
// Ports:
//   clk            clock
//   rst            asynchronous, active-low reset
//   move_left      left key (synchronised, active-high)
//   move_right     right key (synchronised, active-high)
//   widen_req      single-cycle power-up request
//   freeze         suspends motion and the power-up timer
//   x, y           current pixel coordinates
//   active_pixels  high inside the visible region
//   vga_color      combinational draw colour for (x, y)
//   paddle_x/y     registered top-left corner of the paddle
//   paddle_width   registered width (normal or widened)
//   paddle_height  registered height
//   paddle_dir     registered direction: 00 idle, 01 left, 10 right
// ---------------------------------------------------------------------------
module paddle_motion #(
    parameter int          TICK_DIV      = 208333,
    parameter int          SCREEN_W      = 640,
    parameter int          PADDLE_Y      = 440,
    parameter int          PADDLE_W      = 100,
    parameter int          PADDLE_WIDE_W = 160,
    parameter int          PADDLE_H      = 20,
    parameter int          MAX_SPEED     = 4,
    parameter int          ACCEL_TICKS   = 8,
    parameter int          WIDE_TICKS    = 600,
    parameter logic [23:0] COLOR         = 24'hFFFFFF,
    parameter logic [23:0] WIDE_COLOR    = 24'h00FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        widen_req,
    input  logic        freeze,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        active_pixels,
    output logic [23:0] vga_color,
    output logic [9:0]  paddle_x,
    output logic [9:0]  paddle_y,
    output logic [9:0]  paddle_width,
    output logic [9:0]  paddle_height,
    output logic [1:0]  paddle_dir
);

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW  = $clog2(ACCEL_TICKS + 1);
    localparam int SW  = $clog2(MAX_SPEED + 1);
    localparam int WTW = $clog2(WIDE_TICKS + 1);

    // Half of the width difference: widening/narrowing keeps the centre put.
    localparam logic [10:0] L_SCREEN     = 11'(SCREEN_W);
    localparam logic [10:0] L_D          = 11'((PADDLE_WIDE_W - PADDLE_W) / 2);
    localparam logic [10:0] L_WIDE_LIM   = 11'(SCREEN_W - PADDLE_WIDE_W);
    localparam logic [10:0] L_NARROW_LIM = 11'(SCREEN_W - PADDLE_W);
    localparam logic [10:0] L_PY         = 11'(PADDLE_Y);
    localparam logic [10:0] L_PH         = 11'(PADDLE_H);
    localparam logic [9:0]  RESET_X      = 10'((SCREEN_W - PADDLE_W) / 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LEFT  = 2'b01,
        ST_RIGHT = 2'b10
    } state_t;

    logic [TCW-1:0] r_tick_cnt;
    logic           r_tick;
    state_t         r_state;
    logic [SW-1:0]  r_speed;
    logic [HW-1:0]  r_hold;
    logic [WTW-1:0] r_timer;
    logic           r_pending;
    logic           r_wide;
    logic [9:0]     r_px;
    logic [9:0]     r_py;
    logic [9:0]     r_width;
    logic [9:0]     r_height;

    state_t         w_next_state;
    logic           w_reverse;
    logic           w_widen;
    logic [HW-1:0]  w_hold_inc;
    logic [10:0]    w_px11;
    logic [10:0]    w_step;
    logic [10:0]    w_lim;
    logic [10:0]    w_sum;
    logic [10:0]    w_move_x;
    logic [10:0]    w_wide_x;
    logic [10:0]    w_narrow_sum;
    logic [10:0]    w_narrow_x;
    logic [10:0]    w_pix_x;
    logic [10:0]    w_pix_y;
    logic           w_in_box;

    // ------------------------------------------------------------------
    // Motion tick: one-cycle pulse in the cycle after the count wraps.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_tick_cnt == TCW'(TICK_DIV - 1)) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            r_tick     <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and candidate positions, all in 11 bits so that sums
    // near the right edge cannot wrap before clamping.
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = ST_IDLE;
        if (move_left && !move_right)
            w_next_state = ST_LEFT;
        else if (move_right && !move_left)
            w_next_state = ST_RIGHT;

        // A reversal moves at speed 1 on the reversing tick itself.
        w_reverse  = (r_state != ST_IDLE) && (w_next_state != ST_IDLE) &&
                     (w_next_state != r_state);
        w_widen    = r_pending | widen_req;
        w_hold_inc = r_hold + 1'b1;

        w_px11 = {1'b0, r_px};
        w_step = w_reverse ? 11'd1 : 11'(r_speed);
        w_lim  = L_SCREEN - {1'b0, r_width};
        w_sum  = w_px11 + w_step;

        w_move_x = w_px11;
        if (w_next_state == ST_LEFT)
            w_move_x = (w_px11 >= w_step) ? (w_px11 - w_step) : 11'd0;
        else if (w_next_state == ST_RIGHT)
            w_move_x = (w_sum > w_lim) ? w_lim : w_sum;

        if (w_px11 < L_D)
            w_wide_x = 11'd0;
        else if ((w_px11 - L_D) > L_WIDE_LIM)
            w_wide_x = L_WIDE_LIM;
        else
            w_wide_x = w_px11 - L_D;

        w_narrow_sum = w_px11 + L_D;
        w_narrow_x   = (w_narrow_sum > L_NARROW_LIM) ? L_NARROW_LIM : w_narrow_sum;
    end

    // ------------------------------------------------------------------
    // Direction FSM, speed ramp, power-up and position.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_speed   <= SW'(1);
            r_hold    <= '0;
            r_timer   <= '0;
            r_pending <= 1'b0;
            r_wide    <= 1'b0;
            r_px      <= RESET_X;
            r_py      <= 10'(PADDLE_Y);
            r_width   <= 10'(PADDLE_W);
            r_height  <= 10'(PADDLE_H);
        end else if (freeze) begin
            // Frozen: no motion, timer held, but requests still latch.
            r_state   <= ST_IDLE;
            r_speed   <= SW'(1);
            r_hold    <= '0;
            r_pending <= r_pending | widen_req;
        end else if (r_tick) begin
            r_state <= w_next_state;

            if (w_next_state == ST_IDLE || w_reverse) begin
                r_speed <= SW'(1);
                r_hold  <= '0;
            end else if (w_hold_inc == HW'(ACCEL_TICKS)) begin
                r_hold <= '0;
                if (r_speed != SW'(MAX_SPEED))
                    r_speed <= r_speed + 1'b1;
            end else begin
                r_hold <= w_hold_inc;
            end

            // Power-up handling replaces motion on the ticks it acts on;
            // a request wins over a simultaneous expiry. A retrigger while
            // already wide leaves the position untouched.
            r_pending <= 1'b0;
            if (w_widen) begin
                r_timer <= WTW'(WIDE_TICKS);
                if (!r_wide) begin
                    r_wide  <= 1'b1;
                    r_width <= 10'(PADDLE_WIDE_W);
                    r_px    <= w_wide_x[9:0];
                end
            end else if (r_wide && r_timer == WTW'(1)) begin
                r_wide  <= 1'b0;
                r_width <= 10'(PADDLE_W);
                r_px    <= w_narrow_x[9:0];
                r_timer <= '0;
            end else begin
                if (r_wide)
                    r_timer <= r_timer - 1'b1;
                r_px <= w_move_x[9:0];
            end
        end else begin
            r_pending <= r_pending | widen_req;
        end
    end

    // ------------------------------------------------------------------
    // Draw: zero latency from x/y against the registered geometry.
    // ------------------------------------------------------------------
    always_comb begin
        w_pix_x  = {1'b0, x};
        w_pix_y  = {1'b0, y};
        w_in_box = (w_pix_x >= w_px11) && (w_pix_x < (w_px11 + {1'b0, r_width})) &&
                   (w_pix_y >= L_PY) && (w_pix_y < (L_PY + L_PH));
        vga_color = 24'h000000;
        if (active_pixels && w_in_box)
            vga_color = r_wide ? WIDE_COLOR : COLOR;
    end

    assign paddle_x      = r_px;
    assign paddle_y      = r_py;
    assign paddle_width  = r_width;
    assign paddle_height = r_height;
    assign paddle_dir    = r_state;

endmodule

// File: tb/tb_paddle_motion.sv
// ---------------------------------------------------------------------------
// tb_paddle_motion
//
// Scoreboard bench for paddle_motion with a small tick/accel/power-up
// configuration. A driver issues one stimulus per cycle, advances a
// behavioural model built from the game rules and pushes the expected
// outputs; a monitor pops and compares on every falling edge. Directed
// spot checks pin down the numbers of the test plan.
// ---------------------------------------------------------------------------
module tb_paddle_motion;

    localparam int TD   = 4;
    localparam int SCW  = 640;
    localparam int PW   = 100;
    localparam int PWW  = 160;
    localparam int DW   = (PWW - PW) / 2;
    localparam int MAXS = 3;
    localparam int ACC  = 2;
    localparam int WT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        move_left = 1'b0, move_right = 1'b0, widen_req = 1'b0, freeze = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic        active_pixels = 1'b0;
    logic [23:0] vga_color;
    logic [9:0]  paddle_x, paddle_y, paddle_width, paddle_height;
    logic [1:0]  paddle_dir;

    paddle_motion #(
        .TICK_DIV(TD), .SCREEN_W(SCW), .PADDLE_Y(440), .PADDLE_W(PW),
        .PADDLE_WIDE_W(PWW), .PADDLE_H(20), .MAX_SPEED(MAXS),
        .ACCEL_TICKS(ACC), .WIDE_TICKS(WT),
        .COLOR(24'hFFFFFF), .WIDE_COLOR(24'h00FFFF)
    ) dut (
        .clk(clk), .rst(rst), .move_left(move_left), .move_right(move_right),
        .widen_req(widen_req), .freeze(freeze), .x(x), .y(y),
        .active_pixels(active_pixels), .vga_color(vga_color),
        .paddle_x(paddle_x), .paddle_y(paddle_y), .paddle_width(paddle_width),
        .paddle_height(paddle_height), .paddle_dir(paddle_dir)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  px;
        logic [9:0]  w;
        logic [1:0]  dir;
        logic [23:0] col;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_edge = 1;   // index of the next rising edge since reset release

    // Behavioural model state
    int m_px, m_w, m_dir, m_spd, m_hold, m_tmr;
    bit m_pend, m_wide;

    task automatic model_reset();
        m_px = (SCW - PW) / 2; m_w = PW; m_dir = 0; m_spd = 1; m_hold = 0;
        m_tmr = 0; m_pend = 0; m_wide = 0;
    endtask

    function automatic logic [23:0] exp_color(input int xx, input int yy, input logic act);
        if (act && xx >= m_px && xx < m_px + m_w && yy >= 440 && yy < 460)
            return m_wide ? 24'h00FFFF : 24'hFFFFFF;
        return 24'h000000;
    endfunction

    task automatic model_step(input logic ml, input logic mr, input logic wr,
                              input logic fr, input bit is_tick);
        int  want, step, t;
        bit  rev;
        if (fr) begin
            m_dir = 0; m_spd = 1; m_hold = 0;
            if (wr) m_pend = 1;
            return;
        end
        if (!is_tick) begin
            if (wr) m_pend = 1;
            return;
        end
        want = (ml && !mr) ? 1 : ((mr && !ml) ? 2 : 0);
        rev  = (m_dir != 0) && (want != 0) && (want != m_dir);
        step = rev ? 1 : m_spd;
        if (m_pend || wr) begin
            if (!m_wide) begin
                t = m_px - DW;
                if (t < 0) t = 0;
                if (t > SCW - PWW) t = SCW - PWW;
                m_px = t; m_w = PWW; m_wide = 1;
            end
            m_tmr = WT;
        end else if (m_wide && m_tmr == 1) begin
            m_wide = 0; m_w = PW; m_tmr = 0;
            m_px = (m_px + DW > SCW - PW) ? SCW - PW : m_px + DW;
        end else begin
            if (m_wide) m_tmr = m_tmr - 1;
            if (want == 1) m_px = (m_px >= step) ? m_px - step : 0;
            if (want == 2) m_px = (m_px + step > SCW - m_w) ? SCW - m_w : m_px + step;
        end
        m_pend = 0;
        if (want == 0 || rev) begin
            m_spd = 1; m_hold = 0;
        end else begin
            m_hold = m_hold + 1;
            if (m_hold == ACC) begin
                m_hold = 0;
                if (m_spd < MAXS) m_spd = m_spd + 1;
            end
        end
        m_dir = want;
    endtask

    // One clock cycle of stimulus; entered and left at rising edge + 1.
    task automatic cyc(input logic ml, input logic mr, input logic wr,
                       input logic fr, input logic rv);
        exp_t e;
        bit   is_tick;
        move_left = ml; move_right = mr; widen_req = wr; freeze = fr; rst = rv;
        x = 10'($urandom_range(0, 699));
        y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                        : 10'($urandom_range(430, 470));
        active_pixels = ($urandom_range(0, 7) != 0);
        if (!rv) begin
            model_reset();
            n_edge = 1;
        end
        e.px = 10'(m_px); e.w = 10'(m_w); e.dir = 2'(m_dir);
        e.col = exp_color(int'(x), int'(y), active_pixels);
        sb_q.push_back(e);
        if (rv) begin
            is_tick = (n_edge % TD == 1) && (n_edge > 1);
            model_step(ml, mr, wr, fr, is_tick);
            n_edge = n_edge + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_ticks(input int k, input logic ml, input logic mr,
                             input logic wr, input logic fr);
        int  done = 0;
        bit  first = 1;
        bit  is_tick;
        while (done < k) begin
            is_tick = (n_edge % TD == 1) && (n_edge > 1);
            cyc(ml, mr, first ? wr : 1'b0, fr, 1'b1);
            first = 0;
            if (is_tick) done = done + 1;
        end
    endtask

    task automatic spot(input string nm, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic color_spot(input string nm, input logic [9:0] xx, input logic [9:0] yy,
                              input logic act, input logic [23:0] req);
        logic [9:0] sx, sy;
        logic       sa;
        sx = x; sy = y; sa = active_pixels;
        x = xx; y = yy; active_pixels = act;
        #1;
        checks = checks + 1;
        if (vga_color !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %06h expected %06h", nm, vga_color, req);
        end
        x = sx; y = sy; active_pixels = sa;
    endtask

    // Monitor: every cycle the DUT presents geometry/colour; pop and compare.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            checks = checks + 1;
            if (paddle_x !== mon_e.px || paddle_width !== mon_e.w ||
                paddle_dir !== mon_e.dir || vga_color !== mon_e.col ||
                paddle_y !== 10'd440 || paddle_height !== 10'd20) begin
                errors = errors + 1;
                $display("FAIL scoreboard t=%0t: got x=%0d w=%0d dir=%0d col=%06h y=%0d h=%0d expected x=%0d w=%0d dir=%0d col=%06h y=440 h=20",
                         $time, paddle_x, paddle_width, paddle_dir, vga_color,
                         paddle_y, paddle_height, mon_e.px, mon_e.w, mon_e.dir, mon_e.col);
            end
        end
    end

    initial begin
        int ramp[7] = '{271, 272, 274, 276, 279, 282, 285};
        int guard;
        model_reset();
        @(posedge clk); #1;
        repeat (3) cyc(0, 0, 0, 0, 0);
        spot("reset_x", int'(paddle_x), 270);
        spot("reset_w", int'(paddle_width), 100);

        // Reset and idle ticks
        run_ticks(2, 0, 0, 0, 0);
        spot("idle_x", int'(paddle_x), 270);
        spot("idle_dir", int'(paddle_dir), 0);

        // Ramp
        for (int i = 0; i < 7; i++) begin
            run_ticks(1, 0, 1, 0, 0);
            spot("ramp_x", int'(paddle_x), ramp[i]);
            spot("ramp_dir", int'(paddle_dir), 2);
        end

        // Right wall clamp
        run_ticks(90, 0, 1, 0, 0);
        spot("right_clamp", int'(paddle_x), 540);

        // Reversal at speed 3 moves by 1
        run_ticks(1, 1, 0, 0, 0);
        spot("reverse_x", int'(paddle_x), 539);
        spot("reverse_dir", int'(paddle_dir), 1);

        // Left wall clamp
        run_ticks(200, 1, 0, 0, 0);
        spot("left_clamp", int'(paddle_x), 0);

        // Both keys: idle, speed back to 1
        run_ticks(3, 0, 1, 0, 0);
        spot("right3_x", int'(paddle_x), 3);
        run_ticks(1, 1, 1, 0, 0);
        spot("both_x", int'(paddle_x), 3);
        spot("both_dir", int'(paddle_dir), 0);
        run_ticks(1, 0, 1, 0, 0);
        spot("after_both_x", int'(paddle_x), 4);

        // Power-up at the wall
        run_ticks(10, 1, 0, 0, 0);
        spot("wall_x", int'(paddle_x), 0);
        run_ticks(1, 0, 0, 1, 0);
        spot("widen_w", int'(paddle_width), 160);
        spot("widen_x", int'(paddle_x), 0);
        color_spot("wide_color_in", 10'd5, 10'd450, 1'b1, 24'h00FFFF);
        color_spot("wide_color_out", 10'd200, 10'd450, 1'b1, 24'h000000);
        color_spot("wide_color_blank", 10'd5, 10'd450, 1'b0, 24'h000000);
        run_ticks(2, 0, 0, 0, 0);
        spot("wide_hold_w", int'(paddle_width), 160);
        run_ticks(1, 0, 0, 0, 0);
        spot("narrow_w", int'(paddle_width), 100);
        spot("narrow_x", int'(paddle_x), 30);
        color_spot("narrow_color", 10'd30, 10'd440, 1'b1, 24'hFFFFFF);

        // Retrigger on the expiry tick
        run_ticks(1, 0, 0, 1, 0);
        run_ticks(2, 0, 0, 0, 0);
        run_ticks(1, 0, 0, 1, 0);
        spot("retrigger_w", int'(paddle_width), 160);
        run_ticks(2, 0, 0, 0, 0);
        spot("retrigger_hold_w", int'(paddle_width), 160);
        run_ticks(1, 0, 0, 0, 0);
        spot("retrigger_end_x", int'(paddle_x), 30);

        // Freeze holds motion and the timer
        run_ticks(1, 0, 0, 1, 0);
        run_ticks(5, 0, 1, 0, 1);
        spot("freeze_x", int'(paddle_x), 0);
        spot("freeze_dir", int'(paddle_dir), 0);
        spot("freeze_w", int'(paddle_width), 160);
        run_ticks(1, 0, 1, 0, 0);
        spot("unfreeze_x", int'(paddle_x), 1);
        run_ticks(1, 0, 0, 0, 0);
        spot("unfreeze_w", int'(paddle_width), 160);
        run_ticks(1, 0, 0, 0, 0);
        spot("unfreeze_narrow_x", int'(paddle_x), 31);

        // Mid-motion reset drops the pending request
        run_ticks(2, 0, 1, 0, 0);
        cyc(0, 1, 1, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        spot("midreset_x", int'(paddle_x), 270);
        run_ticks(1, 0, 0, 0, 0);
        spot("midreset_w", int'(paddle_width), 100);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 299) != 0));
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(negedge clk); #1;
            guard = guard + 1;
        end
        if (sb_q.size() > 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/paddle_motion.md
# paddle_motion

Parametrised paddle controller for the brick-breaker game. It is the next generation of the single-speed paddle. It adds:
- configurable screen and paddle geometry;
- speed ramping while a direction is held;
- a timed wide-paddle power-up with re-centring;
- a freeze input;
- a direction output the ball logic uses for spin.

It sits between the debounced key inputs and the ball/collision and VGA mixing logic.

## Interface
- TICK_DIV, 208333: clk cycles per motion tick.
- SCREEN_W, 640: visible width in pixels.
- PADDLE_Y, 440: fixed top row.
- PADDLE_W, 100: normal width.
- PADDLE_WIDE_W, 160: widened width, must be >= PADDLE_W, even difference.
- PADDLE_H, 20: height.
- MAX_SPEED, 4: maximum pixels per tick, >= 1.
- ACCEL_TICKS, 8: ticks held at one speed before that speed increments.
- WIDE_TICKS, 600: power-up duration in ticks, >= 1.
- COLOR, 24'hFFFFFF: normal draw colour. WIDE_COLOR, 24'h00FFFF: draw colour while wide.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- move_left, move_right, in, 1 each: active-high, already synchronised by the parent.
- widen_req, in, 1: single-cycle power-up pulse.
- freeze, in, 1: suspends motion and the power-up timer.
- x, y, in, 10 each: current pixel coordinates.
- active_pixels, in, 1: visible region.
- vga_color, out, 24: combinational draw colour.
- paddle_x, paddle_y, paddle_width, paddle_height, out, 10 each: registered geometry.
- paddle_dir, out, 2: registered; 00 idle, 01 left, 10 right.

## Operation
- **Tick generator:** counter runs 0..TICK_DIV-1 and wraps. The registered pulse `tick` is high for exactly one cycle per TICK_DIV cycles, in the cycle after the count reaches TICK_DIV-1.
- **Direction FSM:** states IDLE, LEFT, RIGHT. It is evaluated only on tick with freeze=0.
  - Exactly one key held: go to the matching state.
  - None held or both held: go to IDLE.
  - paddle_dir mirrors the state.
- **Speed:**
  - Range 1..MAX_SPEED, reset value 1.
  - A hold counter increments on each tick spent in the same non-IDLE state.
  - When it reaches ACCEL_TICKS, it clears and speed increments, saturating at MAX_SPEED. The new speed applies from the next tick.
  - Entering IDLE or reversing direction forces speed=1 and hold=0. The reversing tick itself moves at speed 1.
- **Motion:** all arithmetic is 11-bit, with lim = SCREEN_W - paddle_width.
  - LEFT: x = (x >= speed) ? x - speed : 0.
  - RIGHT: x = min(x + speed, lim).
- **Power-up:**
  - widen_req sets a pending flag on any cycle, freeze included.
  - On the next unfrozen tick:
    - If not wide: set wide, width = PADDLE_WIDE_W, x = clamp(x - D, 0, SCREEN_W - PADDLE_WIDE_W) where D = (PADDLE_WIDE_W - PADDLE_W)/2.
    - If already wide: no position change.
    - Either case: load timer = WIDE_TICKS and clear pending.
  - The timer decrements on each unfrozen tick while wide. On the tick where it equals 1, narrow: width = PADDLE_W, x = min(x + D, SCREEN_W - PADDLE_W), timer = 0.
  - On a widen or narrow tick, the position adjustment replaces motion. FSM, speed and hold still update normally.
  - A widen_req arriving on the same tick the timer expires takes priority: the paddle stays wide and the timer reloads.
- **Freeze:** while freeze=1, ticks are ignored for motion and the timer. The FSM is forced to IDLE and speed to 1.
- **Draw:** in_box = x in [px, px+width) and y in [py, py+height), using 11-bit compares. vga_color is:
  - 0 when active_pixels=0;
  - COLOR or WIDE_COLOR when in_box;
  - 0 otherwise.
- **Reset values:**
  - paddle_x = (SCREEN_W - PADDLE_W)/2 (270 with defaults);
  - paddle_y = PADDLE_Y, paddle_width = PADDLE_W, paddle_height = PADDLE_H;
  - paddle_dir = 00, speed = 1;
  - tick counter, hold counter, timer, pending flag and wide flag all 0.

## Timing
- Keys are sampled only in the tick cycle. Geometry and paddle_dir update at the clock edge that ends the tick cycle.
- First possible position change is visible TICK_DIV+1 cycles after reset deassertion.
- vga_color has zero latency from x/y and reflects the registered geometry.
- Asserting rst mid-motion or mid-power-up immediately restores every reset value. The pending request is lost.

## Test plan
Bench parameters: TICK_DIV=4, ACCEL_TICKS=2, MAX_SPEED=3, WIDE_TICKS=3.

1. **Reset and tick:** outputs are 270/440/100/20 with dir 00. tick pulses exactly every 4 cycles.
2. **Ramp:** hold move_right. Successive ticks give x = 271, 272, 274, 276, 279, 282, 285, with dir 10 throughout.
3. **Clamps:**
   - Right held at speed 3 from x=538: x goes to 540, then stays at 540.
   - Left at speed 2 from x=1: x goes to 0.
4. **Reversal and idle:**
   - Right at speed 3, then left only: next tick x decreases by 1.
   - Both keys held: x unchanged, dir 00, speed back to 1.
5. **Power-up at the wall:** widen_req at x=0 gives width 160, x 0, vga_color 00FFFF inside the box. After 3 ticks: width 100, x 30. Retrigger on the expiry tick: stays 160.
6. **Freeze:** keys held with freeze=1: no x change and the timer holds value. On release, motion resumes at speed 1.
